tdc_pulse_pair_gen: RTL
=======================

// Module: tdc_pulse_pair_gen
// PURPOSE
//  On-chip stimulus source for the TDC: a coarse digital-to-time converter, the inverse of the TDC.
//  Turns a programmed cycle delay into a start/stop edge pair separated by exactly that many clocks.
//  Optionally repeats the pair in a burst for averaging.
//  Sits beside tt_um_hpretl_tt06_tdc; start_o/stop_o feed the TDC start/stop inputs for self-calibration.
// PARAMETERS
//  CW  8  width of coarse delay and gap fields (cycles)
//  RW  4  width of repeat field; pairs per burst = cfg_repeat+1
// PORTS
//  clk         in   1   single clock; all logic on rising edge
//  rst         in   1   reset, asynchronous, active-high
//  cfg_valid   in   1   request a burst; held until accepted
//  cfg_ready   out  1   high only in IDLE; accept = cfg_valid & cfg_ready
//  cfg_coarse  in   CW  start->stop spacing in cycles, sampled at accept
//  cfg_gap     in   CW  idle cycles after stop before next start, sampled at accept
//  cfg_repeat  in   RW  extra pairs after the first, sampled at accept
//  abort       in   1   synchronous burst cancel
//  start_o     out  1   one-cycle start pulse, registered
//  stop_o      out  1   one-cycle stop pulse, registered
//  busy        out  1   high from the cycle after accept through the last stop cycle
//  done        out  1   one-cycle pulse, cycle after the final stop
//  pair_idx    out  RW  index of the current pair, 0-based
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE; outputs 0 except cfg_ready=1; start_o, stop_o, busy, done, pair_idx all 0.
//  FSM states: IDLE, DELAY, GAP.
//   IDLE->DELAY on accept.
//   DELAY->GAP on stop when more pairs remain.
//   DELAY->IDLE on stop of the final pair.
//   GAP->DELAY when the gap count expires; that transition issues the next start.
//  Timing, with accept in cycle T:
//   start_o=1 in cycle T+1.
//   stop_o=1 exactly cfg_coarse cycles after each start_o cycle.
//   next start_o = stop cycle + cfg_gap + 1.
//   done=1 and cfg_ready=1 in the cycle after the final stop.
//   Pair period = coarse+gap+1 cycles.
//  coarse=0: start_o and stop_o high in the same cycle (zero-interval code); DELAY is still entered for bookkeeping.
//  coarse = 2^CW-1 is legal: no wrap; the counter is CW bits, down-counting, and compares to 0.
//  gap=0: next start in the cycle immediately after stop.
//  pair_idx increments on each new start after the first; it holds its last value until the next accept.
//  cfg_valid while busy is ignored and not queued; the cfg_* fields are don't-care outside accept.
//  abort in any non-IDLE cycle:
//   IDLE next cycle; start_o, stop_o, busy = 0.
//   No done; pair_idx cleared.
//   abort also overrides a stop due in the same cycle.
//  abort in IDLE: no effect. abort together with accept: accept is ignored.
//  Reset mid-burst: outputs drop asynchronously with no partial done; the first accept after release behaves normally.
// STRUCTURE
//  tdc_pkg:
//   state_t enum {IDLE, DELAY, GAP}
//   localparams for the default CW/RW.
//  Sub-module tdc_dly_cnt:
//   loadable CW-bit down-counter; inputs load and val; output zero flag.
//   One instance is shared by DELAY and GAP.
//  Top holds the FSM, the repeat counter, and the output registers; the outputs are glitch-free flop outputs.
// TESTING
//  1 coarse=5,gap=3,repeat=0, accept cyc0 -> start@1, stop@6, done@7, ready@7, busy 1..6
//  2 coarse=0,repeat=0 -> start_o=stop_o=1 both @1; done@2
//  3 coarse=2,gap=1,repeat=2 -> starts@1,5,9; stops@3,7,11; pair_idx 0,1,2; done@12
//  4 coarse=255 (CW=8) -> stop@256, no early wrap; done@257
//  5 coarse=10, abort@4 -> start@1 only; no stop, no done; ready@5; new accept works
//  6 rst pulse mid-GAP of a repeat=3 burst -> all outputs 0 asynchronously; cfg_valid held while busy never double-accepted

Source files
------------

// File: rtl/tdc_pkg.sv
// Shared types and default widths for the TDC pulse-pair generator.
package tdc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam int CW_DEF = 8;
    localparam int RW_DEF = 4;

endpackage

// File: rtl/tdc_dly_cnt.sv
// Loadable down-counter shared by the start->stop delay and the inter-pair gap.
// Holds at zero; `one` flags that the next cycle reaches zero.
module tdc_dly_cnt
    import tdc_pkg::*;
#(
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] val,
    output logic          zero,
    output logic          one
);

    logic [CW-1:0] cnt;

    // Load takes priority; otherwise count down and stick at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= val;
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign zero = (cnt == '0);
    assign one  = (cnt == CW'(1));

endmodule

// File: rtl/tdc_pulse_pair_gen.sv
// Coarse digital-to-time converter: emits start/stop pulse pairs spaced by a
// programmed number of clocks, optionally repeated in a burst with a gap.
module tdc_pulse_pair_gen
    import tdc_pkg::*;
#(
    parameter int CW = CW_DEF,
    parameter int RW = RW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [CW-1:0] cfg_coarse,
    input  logic [CW-1:0] cfg_gap,
    input  logic [RW-1:0] cfg_repeat,
    input  logic          abort,
    output logic          start_o,
    output logic          stop_o,
    output logic          busy,
    output logic          done,
    output logic [RW-1:0] pair_idx
);

    state_t        state;
    logic [RW-1:0] rem;
    logic [CW-1:0] coarse_q;
    logic [CW-1:0] gap_q;

    logic          accept;
    logic          cnt_load;
    logic [CW-1:0] cnt_val;
    logic          cnt_zero;
    logic          cnt_one;

    // Abort wins over a simultaneous accept.
    assign accept = cfg_valid & cfg_ready & ~abort;

    // Counter reload: coarse at each start, gap-1 at a stop that leads into GAP.
    always_comb begin
        cnt_load = 1'b0;
        cnt_val  = cfg_coarse;
        if (accept) begin
            cnt_load = 1'b1;
            cnt_val  = cfg_coarse;
        end else if (!abort && cnt_zero) begin
            if (state == GAP) begin
                cnt_load = 1'b1;
                cnt_val  = coarse_q;
            end else if (state == DELAY && rem != '0) begin
                cnt_load = 1'b1;
                cnt_val  = (gap_q == '0) ? coarse_q : (gap_q - CW'(1));
            end
        end
    end

    tdc_dly_cnt #(.CW(CW)) u_dly_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (cnt_load),
        .val  (cnt_val),
        .zero (cnt_zero),
        .one  (cnt_one)
    );

    // Burst parameters are captured once per accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            coarse_q <= cfg_coarse;
            gap_q    <= cfg_gap;
        end
    end

    // Burst FSM with registered pulse and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            start_o   <= 1'b0;
            stop_o    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cfg_ready <= 1'b1;
            pair_idx  <= '0;
            rem       <= '0;
        end else begin
            start_o <= 1'b0;
            stop_o  <= 1'b0;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= DELAY;
                        start_o   <= 1'b1;
                        stop_o    <= (cfg_coarse == '0);
                        busy      <= 1'b1;
                        cfg_ready <= 1'b0;
                        pair_idx  <= '0;
                        rem       <= cfg_repeat;
                    end
                end
                DELAY: begin
                    if (abort) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        cfg_ready <= 1'b1;
                        pair_idx  <= '0;
                    end else if (cnt_zero) begin
                        // This is a stop cycle: chain, rest, or finish.
                        if (rem != '0) begin
                            if (gap_q == '0) begin
                                start_o  <= 1'b1;
                                stop_o   <= (coarse_q == '0);
                                rem      <= rem - RW'(1);
                                pair_idx <= pair_idx + RW'(1);
                            end else begin
                                state <= GAP;
                            end
                        end else begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            cfg_ready <= 1'b1;
                        end
                    end else begin
                        stop_o <= cnt_one;
                    end
                end
                GAP: begin
                    if (abort) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        cfg_ready <= 1'b1;
                        pair_idx  <= '0;
                    end else if (cnt_zero) begin
                        state    <= DELAY;
                        start_o  <= 1'b1;
                        stop_o   <= (coarse_q == '0);
                        rem      <= rem - RW'(1);
                        pair_idx <= pair_idx + RW'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    cfg_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
